reg_file_mp: RTL

Parametrised multi-read-port register file for the datapath: DATA_W-bit entries, 2**ADDR_W deep, NUM_RD registered read ports and one synchronous write port. A built-in clear sequencer zeroes the array after reset or on request and holds `ready` low until it finishes. It replaces the fixed 4×8-bit, 2-read register file and sits between the decoder (addresses) and the ALU/writeback stage.

---
 rtl/reg_file_mp_pkg.sv | 20 ++
 rtl/reg_file_mp_clear_seq.sv | 59 +++++
 rtl/reg_file_mp.sv | 82 ++++++++
 3 files changed

// File: rtl/reg_file_mp_pkg.sv
// reg_file_mp_pkg: shared types and defaults for the multi-read-port register file.
//   state_t        - clear sequencer states (CLEAR walks the array, READY serves traffic)
//   DEF_*          - default DATA_W / ADDR_W / NUM_RD
//   slice_off()    - bit offset of port `port` inside a flattened per-port bus
package reg_file_mp_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_NUM_RD = 2;

    function automatic int slice_off(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_file_mp_clear_seq.sv
// reg_file_mp_clear_seq: FSM that zeroes the array one entry per cycle after
// reset or on clear_req, then holds `ready` high until the next clear.
//   clk, reset     - clock, asynchronous active-low reset
//   clear_req      - restart the walk (only honoured in READY)
//   ready          - 1 while in READY
//   clr_en/clr_addr- clear-write port into the array (writes zero)
module reg_file_mp_clear_seq
    import reg_file_mp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              ready,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state, nxt_state;
    logic [ADDR_W-1:0] idx, nxt_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            state <= nxt_state;
            idx   <= nxt_idx;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        case (state)
            CLEAR: begin
                nxt_idx = idx + 1'b1;
                if (idx == LAST) nxt_state = READY;
            end
            READY: begin
                // idx already 0 here; a clear_req starts the walk from entry 0.
                nxt_idx = '0;
                if (clear_req) nxt_state = CLEAR;
            end
            default: begin
                nxt_state = CLEAR;
                nxt_idx   = '0;
            end
        endcase
    end

    assign ready    = (state == READY);
    assign clr_en   = (state == CLEAR);
    assign clr_addr = idx;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: DATA_W x 2**ADDR_W register file, NUM_RD registered read ports,
// one synchronous write port, built-in clear sequencer.
//   clk, reset         - clock, asynchronous active-low reset
//   clear_req          - request to re-zero the array (READY only)
//   ready              - array valid; writes accepted only while high
//   rd_addr / rd_data  - flattened per-port read address / registered data
//   wr_en/addr/data    - write port
//   wr_drop            - registered pulse: the write of the previous cycle was discarded
// Build option: REG_FILE_MP_BYPASS_EN - forward same-cycle write data to
// matching read ports (READY only). Undefined: reads return the old entry.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_req,
    output logic                     ready,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_drop
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic                         clr_en;
    logic [ADDR_W-1:0]            clr_addr;
    logic                         wr_ok;

    reg_file_mp_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .ready     (ready),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr)
    );

    // Clear wins over any write; a pending clear_req also kills the write.
    assign wr_ok = ready & wr_en & ~clear_req;

    // Storage has no reset: the clear walk is what initialises it.
    always_ff @(posedge clk) begin
        if (clr_en)     mem[clr_addr] <= '0;
        else if (wr_ok) mem[wr_addr]  <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wr_drop <= 1'b0;
        else        wr_drop <= wr_en & ~wr_ok;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] nxt;
        logic [DATA_W-1:0] rd_q;

        assign a = rd_addr[slice_off(i, ADDR_W) +: ADDR_W];

`ifdef REG_FILE_MP_BYPASS_EN
        assign nxt = (wr_ok && (wr_addr == a)) ? wr_data : mem[a];
`else
        assign nxt = mem[a];
`endif

        // Reads return zero for the whole walk, regardless of array contents.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) rd_q <= '0;
            else        rd_q <= ready ? nxt : '0;
        end

        assign rd_data[slice_off(i, DATA_W) +: DATA_W] = rd_q;
    end

endmodule
